// File: rtl/rm_c2lw_pkg.sv
// Shared definitions for the cluster-2 LW runtime-monitor report path.
// Default widths, record layout and report-bit indices.
package rm_c2lw_pkg;

  localparam int unsigned NUM_PROPS_C2LW  = 10;
  localparam int unsigned TS_WIDTH_C2LW   = 32;
  localparam int unsigned FIFO_DEPTH_C2LW = 8;
  localparam int unsigned DROP_WIDTH_C2LW = 16;

  typedef struct packed {
    logic [TS_WIDTH_C2LW-1:0]  ts;
    logic [NUM_PROPS_C2LW-1:0] props;
  } rec_t;

  // Bit positions of each automaton's report inside report_vec.
  localparam int unsigned LTL0 = 0;
  localparam int unsigned LTL1 = 1;
  localparam int unsigned LTL2 = 2;
  localparam int unsigned LTL3 = 3;
  localparam int unsigned LTL4 = 4;
  localparam int unsigned LTL5 = 5;
  localparam int unsigned LTL6 = 6;
  localparam int unsigned LTL7 = 7;
  localparam int unsigned LTL8 = 8;
  localparam int unsigned LTL9 = 9;

endpackage

// File: rtl/rm_sync_fifo.sv
// Generic synchronous FIFO with a registered head word that reads zero when empty.
// A push while full is taken only if a pop happens in the same cycle; pop on empty is ignored.
module rm_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_empty;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;
  logic [AW-1:0]    w_rd_inc;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_do_pop    = i_pop && !w_empty;
  assign w_do_push   = i_push && (!w_full || w_do_pop);
  assign w_rd_inc    = r_rd_ptr + AW'(1);
  assign w_count_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);

  // Head is precomputed so the output is a flop rather than a memory read mux.
  always_comb begin
    w_head_nxt = r_head;
    if (w_count_nxt == '0) begin
      w_head_nxt = '0;
    end else if (w_do_pop) begin
      w_head_nxt = (r_count == CW'(1)) ? i_din : r_mem[w_rd_inc];
    end else if (w_empty) begin
      w_head_nxt = i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= w_rd_inc;
      end
      r_count <= w_count_nxt;
      r_head  <= w_head_nxt;
    end
  end

  assign o_dout  = r_head;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/ltl_report_collector_c2lw.sv
// Collects timestamped LTL violation vectors from the cluster-2 LW automata into a FIFO,
// with sticky per-property mask, saturating drop counter, overflow flag and interrupt.
module ltl_report_collector_c2lw
  import rm_c2lw_pkg::*;
#(
  parameter int unsigned NUM_PROPS  = NUM_PROPS_C2LW,
  parameter int unsigned TS_WIDTH   = TS_WIDTH_C2LW,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_C2LW,
  parameter int unsigned DROP_WIDTH = DROP_WIDTH_C2LW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [NUM_PROPS-1:0]  report_vec,
  input  logic                  clr_sticky,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [NUM_PROPS-1:0]  rec_props,
  output logic [TS_WIDTH-1:0]   rec_ts,
  output logic [NUM_PROPS-1:0]  sticky_mask,
  output logic [DROP_WIDTH-1:0] drop_cnt,
  output logic                  overflow,
  output logic                  irq
);

  localparam int unsigned REC_W = TS_WIDTH + NUM_PROPS;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);

  logic [TS_WIDTH-1:0]   r_ts_cnt;
  logic [NUM_PROPS-1:0]  r_sticky;
  logic [DROP_WIDTH-1:0] r_drop;
  logic                  r_ovf;
  logic                  r_irq;

  logic                  w_push_req;
  logic                  w_pop;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic [REC_W-1:0]      w_head;
  logic                  w_nonempty_nxt;
  logic [NUM_PROPS-1:0]  w_sticky_nxt;
  logic [DROP_WIDTH-1:0] w_drop_base;
  logic [DROP_WIDTH-1:0] w_drop_nxt;
  logic                  w_ovf_nxt;

  assign w_push_req = run && (|report_vec);
  assign w_pop      = !w_empty && rec_ready;
  assign w_accept   = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  rm_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_push_req),
    .i_din   ({r_ts_cnt, report_vec}),
    .i_pop   (rec_ready),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Clear is applied before the same-cycle event so a coincident report/drop survives it.
  always_comb begin
    w_sticky_nxt = clr_sticky ? '0 : r_sticky;
    if (run) begin
      w_sticky_nxt = w_sticky_nxt | report_vec;
    end
    w_drop_base = clr_sticky ? '0 : r_drop;
    w_drop_nxt  = w_drop_base;
    if (w_drop && (w_drop_base != '1)) begin
      w_drop_nxt = w_drop_base + DROP_WIDTH'(1);
    end
    w_ovf_nxt = (clr_sticky ? 1'b0 : r_ovf) | w_drop;
  end

  assign w_nonempty_nxt = w_accept || (w_count > CW'(1)) ||
                          ((w_count == CW'(1)) && !w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts_cnt <= '0;
      r_sticky <= '0;
      r_drop   <= '0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (run) begin
        r_ts_cnt <= r_ts_cnt + TS_WIDTH'(1);
      end
      r_sticky <= w_sticky_nxt;
      r_drop   <= w_drop_nxt;
      r_ovf    <= w_ovf_nxt;
      r_irq    <= w_nonempty_nxt || w_ovf_nxt;
    end
  end

  assign rec_valid   = !w_empty;
  assign rec_props   = w_head[NUM_PROPS-1:0];
  assign rec_ts      = w_head[REC_W-1:NUM_PROPS];
  assign sticky_mask = r_sticky;
  assign drop_cnt    = r_drop;
  assign overflow    = r_ovf;
  assign irq         = r_irq;

endmodule
